// File: rtl/jtkiwi_obj_pkg.sv
// Shared definitions for the SETA object line-drawing engine: attribute bit
// positions, object geometry and the draw FSM encoding.
package jtkiwi_obj_pkg;

  localparam int ATTR_HFLIP  = 15;
  localparam int ATTR_VFLIP  = 14;
  localparam int ATTR_PAL_HI = 13;
  localparam int ATTR_PAL_LO = 9;

  localparam int OBJ_W  = 16;
  localparam int HALF_W = OBJ_W / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  // Line-buffer word: palette in the upper bits, 4bpp pixel in the lower.
  function automatic logic [8:0] buf_word(input logic [4:0] pal, input logic [3:0] pix);
    return {pal, pix};
  endfunction

endpackage

// File: rtl/jtkiwi_obj_draw_pxl.sv
// Eight-pixel plane shifter: holds one 32-bit graphics word (one byte per
// bit-plane) and presents the current pixel, shifting toward the next one.
module jtkiwi_obj_draw_pxl (
  input  logic        clk,
  input  logic        load,
  input  logic        shift,
  input  logic        eh,
  input  logic [31:0] din,
  output logic [3:0]  pix
);

  logic [31:0] data;

  // NOTE: pure datapath register with no reset; its contents are only
  // observed in DRAW, which is always preceded by a load.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= din;
    end else if (shift) begin
      for (int k = 0; k < 4; k++) begin
        data[8*k +: 8] <= eh ? {1'b0, data[8*k+1 +: 7]} : {data[8*k +: 7], 1'b0};
      end
    end
  end

  // Unflipped rows read each plane MSB first; flipped rows read LSB first.
  assign pix = eh ? {data[24], data[16], data[8], data[0]}
                  : {data[31], data[23], data[15], data[7]};

endmodule

// File: rtl/jtkiwi_obj_draw.sv
// Object line-drawing engine: accepts one 16-pixel object row per draw
// request, fetches its two ROM words and writes opaque pixels to the line buffer.
module jtkiwi_obj_draw
  import jtkiwi_obj_pkg::*;
#(
  parameter logic SWAP_HALVES = 1'b0
) (
  input  logic        rst,
  input  logic        clk,

  input  logic        draw,
  output logic        busy,
  input  logic [15:0] code,
  input  logic [15:0] attr,
  input  logic [8:0]  xpos,
  input  logic [3:0]  ysub,
  input  logic        flip,

  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,

  output logic [8:0]  buf_addr,
  output logic        buf_we,
  output logic [8:0]  buf_din,

  input  logic [7:0]  debug_bus
);

  state_t      state, state_nx;
  logic        accept;
  logic        load;
  logic        settled;
  logic        eh;
  logic        second;
  logic [2:0]  cnt;
  logic [4:0]  pal;
  logic [8:0]  x;
  logic [3:0]  pix;
  logic [3:0]  col;
  logic        eh_in;
  logic [3:0]  row_in;

  logic unused;
  assign unused = ^{debug_bus, code[15:13], attr[8:0]};

  assign eh_in  = attr[ATTR_HFLIP] ^ flip;
  assign row_in = ysub ^ {4{attr[ATTR_VFLIP]}};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (draw) begin
          state_nx = ST_FETCH;
          accept   = 1'b1;
        end
      end
      ST_FETCH: begin
        // rom_ok in the first FETCH cycle still refers to the previous address.
        if (settled && rom_ok) begin
          state_nx = ST_DRAW;
          load     = 1'b1;
        end
      end
      ST_DRAW: begin
        if (cnt == 3'(HALF_W - 1)) state_nx = second ? ST_IDLE : ST_FETCH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settled  <= 1'b0;
      eh       <= 1'b0;
      second   <= 1'b0;
      cnt      <= 3'd0;
      pal      <= 5'd0;
      x        <= 9'd0;
      rom_addr <= 18'd0;
    end else begin
      settled <= (state == ST_FETCH);
      if (accept) begin
        eh       <= eh_in;
        pal      <= attr[ATTR_PAL_HI:ATTR_PAL_LO];
        x        <= xpos;
        second   <= 1'b0;
        cnt      <= 3'd0;
        rom_addr <= {code[12:0], row_in, SWAP_HALVES ^ eh_in};
      end else if (state == ST_DRAW) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'(HALF_W - 1) && !second) begin
          second      <= 1'b1;
          rom_addr[0] <= ~rom_addr[0];
        end
      end
    end
  end

  jtkiwi_obj_draw_pxl u_pxl (
    .clk   (clk),
    .load  (load),
    .shift (state == ST_DRAW),
    .eh    (eh),
    .din   (rom_data),
    .pix   (pix)
  );

  assign col    = {second, cnt};
  assign busy   = (state != ST_IDLE);
  assign rom_cs = (state == ST_FETCH);

  always_comb begin
    buf_we   = 1'b0;
    buf_addr = 9'd0;
    buf_din  = 9'd0;
    if (state == ST_DRAW) begin
      buf_we   = (pix != 4'd0);
      buf_addr = x + {5'd0, col};
      buf_din  = buf_word(pal, pix);
    end
  end

endmodule

// File: tb/tb_jtkiwi_obj_draw.sv
// Directed bench for jtkiwi_obj_draw: a two-word ROM model selected by the
// half bit, a negedge monitor logging fetches/writes, and hand-computed rows.
module tb_jtkiwi_obj_draw;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        draw = 1'b0;
  logic        busy;
  logic [15:0] code = '0;
  logic [15:0] attr = '0;
  logic [8:0]  xpos = '0;
  logic [3:0]  ysub = '0;
  logic        flip = 1'b0;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok = 1'b1;
  logic [31:0] rom_data;
  logic [8:0]  buf_addr;
  logic        buf_we;
  logic [8:0]  buf_din;
  logic [7:0]  debug_bus = '0;

  // Words chosen so that unflipped pixels read 1..8 and 9..15,7.
  localparam logic [31:0] WORD_A = 32'h011E66AA;
  localparam logic [31:0] WORD_B = 32'hFE1F67AB;

  logic [31:0] w_h0 = WORD_A;
  logic [31:0] w_h1 = WORD_B;
  assign rom_data = rom_addr[0] ? w_h1 : w_h0;

  jtkiwi_obj_draw dut (
    .rst       (rst),
    .clk       (clk),
    .draw      (draw),
    .busy      (busy),
    .code      (code),
    .attr      (attr),
    .xpos      (xpos),
    .ysub      (ysub),
    .flip      (flip),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_ok    (rom_ok),
    .rom_data  (rom_data),
    .buf_addr  (buf_addr),
    .buf_we    (buf_we),
    .buf_din   (buf_din),
    .debug_bus (debug_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [17:0] fetch_q[$];
  logic [8:0]  wa_q[$];
  logic [8:0]  wd_q[$];
  int          busy_cnt = 0;
  int          overlap = 0;
  logic        prev_cs = 1'b0;

  logic [3:0] pix_a[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic [3:0] pix_b[8] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd7};
  logic [8:0] exp_a[16];
  logic [8:0] exp_d[16];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rom_cs && !prev_cs) fetch_q.push_back(rom_addr);
    prev_cs = rom_cs;
    if (buf_we) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_din);
      if (rom_cs) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_draw(input logic [15:0] c, input logic [15:0] a,
                            input logic [8:0] xp, input logic [3:0] ys);
    @(posedge clk);
    #1;
    fetch_q.delete();
    wa_q.delete();
    wd_q.delete();
    busy_cnt = 0;
    overlap  = 0;
    code = c; attr = a; xpos = xp; ysub = ys;
    draw = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_fetch(input string tag, input logic [17:0] f0, input logic [17:0] f1);
    check({tag, "_nfetch"}, fetch_q.size(), 2);
    if (fetch_q.size() > 0) check({tag, "_fetch0"}, 32'(fetch_q[0]), 32'(f0));
    if (fetch_q.size() > 1) check({tag, "_fetch1"}, 32'(fetch_q[1]), 32'(f1));
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwr"}, wa_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(exp_a[i]));
        check($sformatf("%s_din%0d", tag, i), 32'(wd_q[i]), 32'(exp_d[i]));
      end
    end
    check({tag, "_cs_during_we"}, overlap, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_cs", 32'(rom_cs), 0);
    check("rst_we", 32'(buf_we), 0);
    check("rst_addr", 32'(rom_addr), 0);

    // 1: plain row, first-cycle timing, 20 busy cycles
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 9'(9'h040 + c);
      exp_d[c] = {5'd0, (c < 8) ? pix_a[c] : pix_b[c-8]};
    end
    start_draw(16'h0012, 16'h0000, 9'h040, 4'd3);
    @(negedge clk);
    check("t1_busy_c1", 32'(busy), 1);
    check("t1_cs_c1", 32'(rom_cs), 1);
    check("t1_addr_c1", 32'(rom_addr), 32'h00246);
    wait_idle("t1");
    check("t1_busycnt", busy_cnt, 20);
    check_fetch("t1", 18'h00246, 18'h00247);
    check_writes("t1", 16);

    // 2: hflip -> half 1 first, reversed pixels
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 9'(9'h040 + c);
      exp_d[c] = {5'd0, (c < 8) ? pix_b[7-c] : pix_a[15-c]};
    end
    start_draw(16'h0012, 16'h8000, 9'h040, 4'd3);
    wait_idle("t2");
    check("t2_busycnt", busy_cnt, 20);
    check_fetch("t2", 18'h00247, 18'h00246);
    check_writes("t2", 16);

    // 3: vflip -> row 0xC, palette 5
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 9'(9'h040 + c);
      exp_d[c] = {5'd5, (c < 8) ? pix_a[c] : pix_b[c-8]};
    end
    start_draw(16'h0012, 16'h4A00, 9'h040, 4'd3);
    wait_idle("t3");
    check_fetch("t3", 18'h00258, 18'h00259);
    check_writes("t3", 16);

    // 4: transparent first word, solid second word, palette 3
    w_h0 = 32'h00000000;
    w_h1 = 32'hFFFFFFFF;
    for (int c = 0; c < 8; c++) begin
      exp_a[c] = 9'(9'h048 + c);
      exp_d[c] = {5'd3, 4'hF};
    end
    start_draw(16'h0012, 16'h0600, 9'h040, 4'd3);
    wait_idle("t4");
    check("t4_busycnt", busy_cnt, 20);
    check_writes("t4", 8);
    w_h0 = WORD_A;
    w_h1 = WORD_B;

    // 5: X wrap-around
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 9'(9'h1FC + c);
      exp_d[c] = {5'd0, (c < 8) ? pix_a[c] : pix_b[c-8]};
    end
    start_draw(16'h0012, 16'h0000, 9'h1FC, 4'd3);
    wait_idle("t5");
    check_writes("t5", 16);

    // 6: ROM stall; rom_ok rises in cycle 5 -> 23 busy cycles
    rom_ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 9'(9'h040 + c);
      exp_d[c] = {5'd0, (c < 8) ? pix_a[c] : pix_b[c-8]};
    end
    start_draw(16'h0012, 16'h0000, 9'h040, 4'd3);
    repeat (4) @(negedge clk);
    check("t6_busy_stall", 32'(busy), 1);
    check("t6_cs_stall", 32'(rom_cs), 1);
    check("t6_nwr_stall", wa_q.size(), 0);
    @(posedge clk);
    #1 rom_ok = 1'b1;
    wait_idle("t6");
    check("t6_busycnt", busy_cnt, 23);
    check_writes("t6", 16);

    // 7: draws while busy are ignored; reset during second DRAW aborts
    start_draw(16'h0012, 16'h0000, 9'h040, 4'd3);
    repeat (3) @(posedge clk);
    #1 draw = 1'b1;
    @(posedge clk);
    #1 draw = 1'b0;
    repeat (6) @(posedge clk);
    #1 draw = 1'b1;
    @(posedge clk);
    #1 draw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t7_busy", 32'(busy), 0);
    check("t7_cs", 32'(rom_cs), 0);
    check("t7_we", 32'(buf_we), 0);
    check("t7_rom_addr", 32'(rom_addr), 0);
    check("t7_buf_addr", 32'(buf_addr), 0);
    check("t7_buf_din", 32'(buf_din), 0);
    check("t7_busycnt", busy_cnt, 15);
    check("t7_nwr_at_rst", wa_q.size(), 11);
    repeat (30) @(negedge clk);
    check("t7_nwr_after", wa_q.size(), 11);
    check("t7_nfetch", fetch_q.size(), 2);
    check("t7_busy_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
